// File: rtl/memory1_stage_pkg.sv
// Shared types for the memory1 stage: inter-stage bundles, dcache request,
// byte-type encodings and the ALE exception code.
package memory1_stage_pkg;

    typedef enum logic [1:0] {
        BT_BYTE = 2'd0,
        BT_HALF = 2'd1,
        BT_WORD = 2'd2
    } byte_type_t;

    localparam logic [5:0] ECODE_ALE = 6'h09;

    typedef struct packed {
        logic       valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] ex_out;
        logic [31:0] rkd;
        logic       is_mem;
        logic       is_store;
        logic       is_ll;
        logic       is_sc;
        logic       is_cacop;
        logic       is_ertn;
        byte_type_t byte_type;
        logic [4:0] rd;
        logic       is_wr_rd;
        logic       is_wr_rd_pc_plus4;
    } execute_memory1_pass_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  ecode;
        logic [31:0] badv;
    } excp_pass_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        is_load;
        logic        is_store;
        logic        mem_req;
        byte_type_t  byte_type;
        logic [4:0]  rd;
        logic        is_wr_rd;
        logic [31:0] result;
    } memory1_memory2_pass_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic        data_valid;
        logic [31:0] data;
    } forward_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        is_store;
        logic        is_cac;
    } dc_req_t;

    function automatic logic mem_is_load(execute_memory1_pass_t p);
        return p.is_mem & ~p.is_store & ~p.is_cacop;
    endfunction

endpackage

// File: rtl/memory1_stage_if.sv
// dcache request channel: valid/ready handshake plus request payload.
interface memory1_stage_if;
    import memory1_stage_pkg::*;

    logic    req_valid;
    logic    req_ready;
    dc_req_t req;

    modport master (output req_valid, output req, input req_ready);
    modport slave  (input req_valid, input req, output req_ready);
endinterface

// File: rtl/memory1_stage_store_align.sv
// Store lane replication, byte strobes and alignment check for one access.
module memory1_stage_store_align
    import memory1_stage_pkg::*;
(
    input  byte_type_t  byte_type_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rkd_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misaligned_o
);

    always_comb begin
        wdata_o      = rkd_i;
        wstrb_o      = 4'hF;
        misaligned_o = 1'b0;
        unique case (byte_type_i)
            BT_BYTE: begin
                wdata_o = {4{rkd_i[7:0]}};
                wstrb_o = 4'b0001 << addr_i;
            end
            BT_HALF: begin
                wdata_o      = {2{rkd_i[15:0]}};
                wstrb_o      = 4'b0011 << {addr_i[1], 1'b0};
                misaligned_o = addr_i[0];
            end
            default: misaligned_o = |addr_i;
        endcase
    end

endmodule

// File: rtl/memory1_stage.sv
// Memory1 stage: ALE check, dcache request handshake, LL/SC llbit, forwarding.
// Optional perf counters under MEM1_PERF_CNT_EN.
module memory1_stage
    import memory1_stage_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  stall_i,
    output logic                  stall_o,
    input  execute_memory1_pass_t pass_in,
    input  excp_pass_t            excp_pass_in,
    output memory1_memory2_pass_t pass_out,
    output excp_pass_t            excp_pass_out,
    output forward_req_t          fwd_req,
    memory1_stage_if.master       dc
`ifdef MEM1_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     perf_mem_ops,
    output logic [PERF_W-1:0]     perf_dc_stall
`endif
);

    execute_memory1_pass_t pass_q, pass_d;
    excp_pass_t            excp_q, excp_d;
    logic llbit_q, llbit_d;
    logic acc_q, acc_d;

    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic        al_misal;

    logic ale, excp_any, sc_ok, mem_do, dc_wait;
    logic req_v, hs, adv, valid_o;

    memory1_stage_store_align u_align (
        .byte_type_i  (pass_q.byte_type),
        .addr_i       (pass_q.ex_out[1:0]),
        .rkd_i        (pass_q.rkd),
        .wdata_o      (al_wdata),
        .wstrb_o      (al_wstrb),
        .misaligned_o (al_misal)
    );

    always_comb begin
        ale      = pass_q.is_mem & al_misal;
        excp_any = excp_q.valid | ale;
        // acc_q keeps a granted sc successful after its llbit is consumed
        sc_ok    = llbit_q | acc_q;
        mem_do   = pass_q.valid & pass_q.is_mem & ~excp_any
                 & ~(pass_q.is_sc & ~sc_ok);
        dc_wait  = mem_do & ~acc_q & ~dc.req_ready;
        stall_o  = stall_i | dc_wait;
        req_v    = mem_do & ~acc_q & ~flush_i;
        hs       = req_v & dc.req_ready;
        adv      = ~stall_o | flush_i;
        valid_o  = pass_q.valid & ~stall_o;

        dc.req_valid    = req_v;
        dc.req.addr     = pass_q.ex_out;
        dc.req.wdata    = al_wdata;
        dc.req.wstrb    = pass_q.is_store ? al_wstrb : 4'h0;
        dc.req.is_store = pass_q.is_store;
        dc.req.is_cac   = pass_q.is_cacop;

        fwd_req.valid      = (pass_q.rd != 5'd0) & pass_q.is_wr_rd
                           & pass_q.valid & ~excp_any;
        fwd_req.idx        = pass_q.rd;
        fwd_req.data_valid = ~mem_is_load(pass_q);
        if (pass_q.is_wr_rd_pc_plus4)
            fwd_req.data = pass_q.pc_plus4;
        else if (pass_q.is_sc)
            fwd_req.data = {31'b0, sc_ok};
        else
            fwd_req.data = pass_q.ex_out;

        pass_out.valid     = valid_o & ~flush_i;
        pass_out.pc        = pass_q.pc;
        pass_out.addr      = pass_q.ex_out;
        pass_out.is_load   = mem_is_load(pass_q);
        pass_out.is_store  = pass_q.is_store;
        pass_out.mem_req   = mem_do;
        pass_out.byte_type = pass_q.byte_type;
        pass_out.rd        = pass_q.rd;
        pass_out.is_wr_rd  = pass_q.is_wr_rd;
        pass_out.result    = fwd_req.data;

        // an exception from an earlier stage takes priority over ALE
        excp_pass_out = excp_q;
        if (!excp_q.valid && ale) begin
            excp_pass_out.ecode = ECODE_ALE;
            excp_pass_out.badv  = pass_q.ex_out;
        end
        excp_pass_out.valid = excp_any & valid_o & ~flush_i;

        acc_d = acc_q;
        if (adv)
            acc_d = 1'b0;
        else if (hs)
            acc_d = 1'b1;

        llbit_d = llbit_q;
        if (hs & pass_q.is_ll)
            llbit_d = 1'b1;
        if (hs & pass_q.is_sc)
            llbit_d = 1'b0;
        if (pass_q.valid & pass_q.is_ertn & ~excp_any & ~flush_i)
            llbit_d = 1'b0;

        pass_d = adv ? pass_in : pass_q;
        excp_d = adv ? excp_pass_in : excp_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_q  <= '0;
            excp_q  <= '0;
            llbit_q <= 1'b0;
            acc_q   <= 1'b0;
        end else begin
            pass_q  <= pass_d;
            excp_q  <= excp_d;
            llbit_q <= llbit_d;
            acc_q   <= acc_d;
        end
    end

`ifdef MEM1_PERF_CNT_EN
    logic [PERF_W-1:0] ops_q, ops_d;
    logic [PERF_W-1:0] dstall_q, dstall_d;

    always_comb begin
        ops_d    = ops_q + PERF_W'(hs);
        dstall_d = dstall_q + PERF_W'(dc_wait);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ops_q    <= '0;
            dstall_q <= '0;
        end else begin
            ops_q    <= ops_d;
            dstall_q <= dstall_d;
        end
    end

    assign perf_mem_ops  = ops_q;
    assign perf_dc_stall = dstall_q;
`endif

endmodule

// File: tb/tb_memory1_stage.sv
// Bench for memory1_stage: behavioural model + per-cycle compare,
// plus directed vectors with hand-computed expectations.
module tb_memory1_stage;
    import memory1_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_i = 1'b0;
    logic stall_i = 1'b0;
    logic stall_o;
    execute_memory1_pass_t pass_in;
    excp_pass_t            excp_in;
    memory1_memory2_pass_t pass_out;
    excp_pass_t            excp_out;
    forward_req_t          fwd;
`ifdef MEM1_PERF_CNT_EN
    logic [31:0] perf_ops, perf_stall;
`endif

    memory1_stage_if dc ();

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    memory1_stage #(.PERF_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .stall_i       (stall_i),
        .stall_o       (stall_o),
        .pass_in       (pass_in),
        .excp_pass_in  (excp_in),
        .pass_out      (pass_out),
        .excp_pass_out (excp_out),
        .fwd_req       (fwd),
        .dc            (dc.master)
`ifdef MEM1_PERF_CNT_EN
        ,
        .perf_mem_ops  (perf_ops),
        .perf_dc_stall (perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    // model: instruction held in the stage, whether it was sent to the
    // dcache, the llbit, and the llbit as seen when the op entered
    execute_memory1_pass_t m_h;
    excp_pass_t            m_e;
    bit m_issued, m_ll, m_sc_ok;
    int m_ops, m_stalls;

    function automatic int m_size();
        case (m_h.byte_type)
            BT_BYTE: return 1;
            BT_HALF: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit m_own_ale();
        return m_h.is_mem && ((int'(m_h.ex_out[1:0]) % m_size()) != 0);
    endfunction

    function automatic bit m_exc();
        return m_e.valid || m_own_ale();
    endfunction

    function automatic bit m_do();
        return m_h.valid && m_h.is_mem && !m_exc()
            && !(m_h.is_sc && !m_sc_ok);
    endfunction

    function automatic bit m_wait();
        return m_do() && !m_issued && !dc.req_ready;
    endfunction

    function automatic bit m_stall();
        return stall_i || m_wait();
    endfunction

    function automatic bit m_req();
        return m_do() && !m_issued && !flush_i;
    endfunction

    function automatic logic [31:0] m_result();
        if (m_h.is_wr_rd_pc_plus4) return m_h.pc_plus4;
        if (m_h.is_sc) return m_sc_ok ? 32'd1 : 32'd0;
        return m_h.ex_out;
    endfunction

    always @(posedge clk) begin
        if (rst_n && dc.req_valid && dc.req_ready) hs_cnt++;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_h = '0; m_e = '0;
            m_ll = 0; m_issued = 0; m_sc_ok = 0;
            m_ops = 0; m_stalls = 0;
        end else begin
            bit req, st, ex;
            req = m_req();
            st  = m_stall();
            ex  = m_exc();
            if (m_wait()) m_stalls++;
            if (req && dc.req_ready) begin
                m_issued = 1;
                m_ops++;
                if (m_h.is_ll) m_ll = 1;
                if (m_h.is_sc) m_ll = 0;
            end
            if (m_h.valid && m_h.is_ertn && !ex && !flush_i) m_ll = 0;
            if (flush_i || !st) begin
                m_h = pass_in; m_e = excp_in;
                m_issued = 0; m_sc_ok = m_ll;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            bit pv, fv, ex;
            int sz, off;
            logic [31:0] w;
            logic [3:0]  s;
            ex = m_exc();
            chk1("stall_o", stall_o, m_stall());
            chk1("req_valid", dc.req_valid, m_req());
            if (m_req()) begin
                sz  = m_size();
                off = int'(m_h.ex_out[1:0]);
                for (int i = 0; i < 4; i++) begin
                    w[8*i +: 8] = m_h.rkd[8*(i % sz) +: 8];
                    s[i] = m_h.is_store && i >= off && i < off + sz;
                end
                chk("req_addr", dc.req.addr, m_h.ex_out);
                chk("req_wdata", dc.req.wdata, w);
                chk("req_wstrb", {28'b0, dc.req.wstrb}, {28'b0, s});
                chk1("req_is_store", dc.req.is_store, m_h.is_store);
            end
            pv = m_h.valid && !m_stall() && !flush_i;
            chk1("pass_valid", pass_out.valid, pv);
            chk1("excp_valid", excp_out.valid, pv && ex);
            if (pv && ex) begin
                chk("excp_ecode", {26'b0, excp_out.ecode},
                    {26'b0, m_e.valid ? m_e.ecode : ECODE_ALE});
                chk("excp_badv", excp_out.badv,
                    m_e.valid ? m_e.badv : m_h.ex_out);
            end
            if (pv) begin
                chk("pass_pc", pass_out.pc, m_h.pc);
                chk("pass_result", pass_out.result, m_result());
                chk1("pass_mem_req", pass_out.mem_req, m_do());
            end
            fv = m_h.valid && m_h.rd != 0 && m_h.is_wr_rd && !ex;
            chk1("fwd_valid", fwd.valid, fv);
            if (fv) begin
                chk("fwd_idx", {27'b0, fwd.idx}, {27'b0, m_h.rd});
                chk1("fwd_data_valid", fwd.data_valid,
                     !(m_h.is_mem && !m_h.is_store && !m_h.is_cacop));
                chk("fwd_data", fwd.data, m_result());
            end
`ifdef MEM1_PERF_CNT_EN
            chk("perf_ops", perf_ops, m_ops);
            chk("perf_stall", perf_stall, m_stalls);
`endif
        end
    end

    function automatic execute_memory1_pass_t mk(
        input bit mem, input bit st, input byte_type_t bt,
        input logic [31:0] addr, input logic [31:0] rkd,
        input logic [4:0] rd);
        execute_memory1_pass_t p;
        p = '0;
        p.valid     = 1'b1;
        p.pc        = 32'h1c00_0000 + addr;
        p.pc_plus4  = p.pc + 32'd4;
        p.ex_out    = addr;
        p.rkd       = rkd;
        p.is_mem    = mem;
        p.is_store  = st;
        p.byte_type = bt;
        p.rd        = rd;
        p.is_wr_rd  = !st;
        return p;
    endfunction

    task automatic send(input execute_memory1_pass_t p, input excp_pass_t e);
        bit adv;
        int n;
        n = 0;
        @(posedge clk); #1;
        pass_in = p; excp_in = e;
        do begin
            @(negedge clk);
            adv = !stall_o || flush_i;
            @(posedge clk); #1;
            n++;
        end while (!adv && n < 50);
        if (!adv) begin
            checks++; errors++;
            $display("FAIL send_timeout: pc %0h never accepted", p.pc);
        end
        pass_in = '0; excp_in = '0;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    initial begin
        execute_memory1_pass_t p;
        excp_pass_t e, none;
        int h0;
        none = '0;
        pass_in = '0; excp_in = '0;
        dc.req_ready = 1'b0;

        repeat (3) @(posedge clk);
        mid();
        chk1("rst_stall", stall_o, 1'b0);
        chk1("rst_req", dc.req_valid, 1'b0);
        chk1("rst_pass", pass_out.valid, 1'b0);
        chk1("rst_excp", excp_out.valid, 1'b0);
        chk1("rst_fwd", fwd.valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dc.req_ready = 1'b1;

        send(mk(1, 1, BT_WORD, 32'h1000, 32'hDEAD_BEEF, 0), none);
        mid();
        chk1("stw_req", dc.req_valid, 1'b1);
        chk("stw_wstrb", {28'b0, dc.req.wstrb}, 32'hF);
        chk("stw_wdata", dc.req.wdata, 32'hDEAD_BEEF);
        chk1("stw_pass", pass_out.valid, 1'b1);

        send(mk(1, 1, BT_BYTE, 32'h1003, 32'h0000_00A5, 0), none);
        mid();
        chk("stb_wstrb", {28'b0, dc.req.wstrb}, 32'h8);
        chk("stb_wdata", dc.req.wdata, 32'hA5A5_A5A5);

        send(mk(1, 1, BT_HALF, 32'h1002, 32'h1234_ABCD, 0), none);
        mid();
        chk("sth_wstrb", {28'b0, dc.req.wstrb}, 32'hC);
        chk("sth_wdata", dc.req.wdata, 32'hABCD_ABCD);

        send(mk(1, 0, BT_WORD, 32'h1002, 0, 5), none);
        mid();
        chk1("ale_req", dc.req_valid, 1'b0);
        chk1("ale_valid", excp_out.valid, 1'b1);
        chk("ale_ecode", {26'b0, excp_out.ecode}, 32'h9);
        chk("ale_badv", excp_out.badv, 32'h1002);
        chk1("ale_fwd", fwd.valid, 1'b0);

        e = '0; e.valid = 1'b1; e.ecode = 6'h3; e.badv = 32'h77;
        send(mk(1, 0, BT_WORD, 32'h1006, 0, 5), e);
        mid();
        chk("early_ecode", {26'b0, excp_out.ecode}, 32'h3);
        chk("early_badv", excp_out.badv, 32'h77);

        dc.req_ready = 1'b0;
        h0 = hs_cnt;
        send(mk(1, 0, BT_WORD, 32'h2000, 0, 6), none);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk1("rdy_low_stall", stall_o, 1'b1);
            @(posedge clk); #1;
        end
        dc.req_ready = 1'b1;
        mid();
        chk1("rdy_hi_stall", stall_o, 1'b0);
        chk1("ld_fwd_valid", fwd.valid, 1'b1);
        chk1("ld_fwd_dv", fwd.data_valid, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("one_accept", 32'(hs_cnt - h0), 32'd1);

        send(mk(1, 0, BT_WORD, 32'h3000, 0, 10), none);
        stall_i = 1'b1;
        mid();
        chk1("si_req1", dc.req_valid, 1'b1);
        @(posedge clk); #1;
        mid();
        chk1("si_req2", dc.req_valid, 1'b0);
        chk1("si_stall", stall_o, 1'b1);
        stall_i = 1'b0;

        p = mk(1, 0, BT_WORD, 32'h4000, 0, 7); p.is_ll = 1'b1;
        send(p, none);
        p = mk(1, 1, BT_WORD, 32'h4000, 32'h55, 8);
        p.is_sc = 1'b1; p.is_wr_rd = 1'b1;
        send(p, none);
        mid();
        chk1("sc1_req", dc.req_valid, 1'b1);
        chk("sc1_data", fwd.data, 32'd1);
        send(p, none);
        mid();
        chk1("sc2_req", dc.req_valid, 1'b0);
        chk1("sc2_dv", fwd.data_valid, 1'b1);
        chk("sc2_data", fwd.data, 32'd0);

        p = mk(1, 0, BT_WORD, 32'h4000, 0, 7); p.is_ll = 1'b1;
        send(p, none);
        p = mk(0, 0, BT_WORD, 32'h0, 0, 0); p.is_ertn = 1'b1;
        send(p, none);
        p = mk(1, 1, BT_WORD, 32'h4000, 32'h66, 8);
        p.is_sc = 1'b1; p.is_wr_rd = 1'b1;
        send(p, none);
        mid();
        chk1("ertn_sc_req", dc.req_valid, 1'b0);

        p = mk(0, 0, BT_WORD, 32'h1234, 0, 1); p.is_wr_rd_pc_plus4 = 1'b1;
        send(p, none);
        mid();
        chk("jirl_data", fwd.data, 32'h1c00_1238);

        dc.req_ready = 1'b0;
        h0 = hs_cnt;
        send(mk(1, 0, BT_WORD, 32'h5000, 0, 9), none);
        flush_i = 1'b1;
        mid();
        chk1("flush_req", dc.req_valid, 1'b0);
        chk1("flush_pass", pass_out.valid, 1'b0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        dc.req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("flush_no_hs", 32'(hs_cnt - h0), 32'd0);
        mid();
        chk1("flush_idle", dc.req_valid, 1'b0);
`ifdef MEM1_PERF_CNT_EN
        chk("perf_ops_total", perf_ops, 32'd8);
        chk("perf_stall_total", perf_stall, 32'd4);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
